inst_encoder: RTL and testbench

Instruction encoder for the RISC-V pipeline's test and boot path. It accepts decoded fields (format, registers, funct3/funct7, signed immediate) over a valid/ready handshake and packs them into 32-bit RV32I instruction words. Immediate bits are placed exactly as the pipeline's immediate generator unpacks them. Encoded words are buffered in a 2-entry FIFO and emitted with an auto-incrementing byte address for writing into instruction memory.

---
 rtl/riscv_enc_pkg.sv | 30 +++
 rtl/enc_fifo2.sv | 56 +++++
 rtl/inst_encoder.sv | 128 ++++++++++++
 tb/tb_inst_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: format enum, opcodes,
// the NOP word and the immediate ranges used by the optional range check.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R      = 3'd0,
        FMT_I_ALU  = 3'd1,
        FMT_I_LOAD = 3'd2,
        FMT_S      = 3'd3,
        FMT_B      = 3'd4
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;

    function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO holding {err, inst[31:0]} words, with an occupancy count.
// Pushing when full or popping when empty is ignored.
module enc_fifo2 (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [32:0] pushData_i,
    input  logic        pop_i,
    output logic [32:0] headData_o,
    output logic [1:0]  count_o
);

    logic [32:0] mem_q [2];
    logic [32:0] mem_d [2];
    logic        wrPtr_q, wrPtr_d;
    logic        rdPtr_q, rdPtr_d;
    logic [1:0]  count_q, count_d;
    logic        doPush, doPop;

    assign doPush = push_i && (count_q != 2'd2);
    assign doPop  = pop_i && (count_q != 2'd0);

    // Accept and pop in the same cycle touch different slots, so order holds.
    always_comb begin
        mem_d   = mem_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) begin
            mem_d[wrPtr_q] = pushData_i;
            wrPtr_d        = ~wrPtr_q;
        end
        if (doPop) begin
            rdPtr_d = ~rdPtr_q;
        end
        count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign headData_o = mem_q[rdPtr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded fields into RV32I words, buffers them and emits them with a byte address.
// Define INST_ENCODER_RANGE_CHECK_EN to replace out-of-range immediates with an erroring NOP.
module inst_encoder
    import riscv_enc_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_fmt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [2:0]    in_funct3,
    input  logic [6:0]    in_funct7,
    input  logic [31:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_inst,
    output logic [AW-1:0] out_addr,
    output logic          out_err
);

    fmt_e        fmt;
    logic [31:0] encInst;
    logic        encErr;
    logic        immOk;
    logic        immFits12;
    logic        immFitsB;

    logic [1:0]    count;
    logic [1:0]    nextCount;
    logic [32:0]   head;
    logic          push;
    logic          pop;
    logic          in_ready_q;
    logic [AW-1:0] addr_q, addr_d;

    assign fmt       = fmt_e'(in_fmt);
    assign immFits12 = imm_in_range(in_imm, IMM12_MIN, IMM12_MAX);
    assign immFitsB  = imm_in_range(in_imm, IMMB_MIN, IMMB_MAX) && !in_imm[0];

    // Bit placement mirrors the pipeline's immediate generator exactly.
    always_comb begin
        encInst = NOP_INST;
        encErr  = 1'b0;
        immOk   = 1'b1;
        case (fmt)
            FMT_R: begin
                encInst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            end
            FMT_I_ALU: begin
                encInst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I_ALU};
                immOk   = immFits12;
            end
            FMT_I_LOAD: begin
                encInst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I_LOAD};
                immOk   = immFits12;
            end
            FMT_S: begin
                encInst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
                immOk   = immFits12;
            end
            FMT_B: begin
                encInst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OP_B};
                immOk   = immFitsB;
            end
            default: begin
                encInst = NOP_INST;
                encErr  = 1'b1;
            end
        endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
        if (!immOk) begin
            encInst = NOP_INST;
            encErr  = 1'b1;
        end
`endif
    end

`ifndef INST_ENCODER_RANGE_CHECK_EN
    logic unusedRangeOk;
    assign unusedRangeOk = immOk;
`endif

    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign nextCount = count + {1'b0, push} - {1'b0, pop};

    enc_fifo2 u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pushData_i ({encErr, encInst}),
        .pop_i      (pop),
        .headData_o (head),
        .count_o    (count)
    );

    // Address wraps naturally at 2^AW since the counter is exactly AW bits wide.
    always_comb begin
        addr_d = addr_q;
        if (pop) begin
            addr_d = addr_q + AW'(4);
        end
    end

    // in_ready is registered from the next occupancy so it never depends on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            addr_q     <= addr_d;
            in_ready_q <= (nextCount < 2'd2);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count != 2'd0);
    assign out_inst  = head[31:0];
    assign out_err   = head[32];
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, a scoreboard model built
// from arithmetic field placement, and a per-cycle compare process.
module tb_inst_encoder;

    localparam int TB_AW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [4:0]       in_rd, in_rs1, in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [TB_AW-1:0] out_addr;
    logic             out_err;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t sbQ[$];
    int   modelAddr = 0;

    always #5 clk = ~clk;

    inst_encoder #(.AW(TB_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err)
    );

    function automatic longint modPos(input longint x, input longint m);
        return ((x % m) + m) % m;
    endfunction

    // Fields are placed by weighting each value with its bit position.
    function automatic exp_t modelEncode(input longint fmt, input longint rd, input longint rs1,
                                         input longint rs2, input longint f3, input longint f7,
                                         input longint imm);
        exp_t   e;
        longint w;
        longint u;
        bit     bad;
        bad   = 1'b0;
        e.err = 1'b0;
        w     = 19;
        case (fmt)
            0: w = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51;
            1, 2: begin
                u   = modPos(imm, 4096);
                w   = u * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + ((fmt == 1) ? 19 : 3);
                bad = (imm < -2048) || (imm > 2047);
            end
            3: begin
                u   = modPos(imm, 4096);
                w   = (u / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096
                      + (u % 32) * 128 + 35;
                bad = (imm < -2048) || (imm > 2047);
            end
            4: begin
                u   = modPos(imm, 8192);
                w   = (u / 4096) * 64'h8000_0000 + ((u / 32) % 64) * 33554432 + rs2 * 1048576
                      + rs1 * 32768 + f3 * 4096 + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + 99;
                bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
            end
            default: begin
                w     = 19;
                e.err = 1'b1;
            end
        endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
        if (bad) begin
            w     = 19;
            e.err = 1'b1;
        end
`endif
        e.inst = w[31:0];
        return e;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input logic [31:0] inst, input logic err, input int addr);
        checkVal("lit_out_valid", 32'(out_valid), 32'd1);
        checkVal("lit_out_inst", out_inst, inst);
        checkVal("lit_out_err", 32'(out_err), 32'(err));
        checkVal("lit_out_addr", 32'(out_addr), 32'(addr));
    endtask

    task automatic setFields(input int fmt, input int rd, input int rs1, input int rs2,
                             input int f3, input int f7, input int imm);
        in_fmt    = 3'(fmt);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 32'(imm);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic applyStimulus(input int fmt, input int rd, input int rs1, input int rs2,
                                 input int f3, input int f7, input int imm);
        bit got;
        got = 1'b0;
        setFields(fmt, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low required=accept at %0t", $time);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Scoreboard update from the handshake rules, independent of DUT outputs.
    always @(posedge clk) begin
        bit doPop;
        bit doPush;
        if (reset) begin
            sbQ.delete();
            modelAddr = 0;
        end else begin
            doPop  = out_ready && (sbQ.size() > 0);
            doPush = in_valid && (sbQ.size() < 2);
            if (doPop) begin
                void'(sbQ.pop_front());
                modelAddr = (modelAddr + 4) % (1 << TB_AW);
            end
            if (doPush) begin
                sbQ.push_back(modelEncode(longint'(in_fmt), longint'(in_rd), longint'(in_rs1),
                                          longint'(in_rs2), longint'(in_funct3),
                                          longint'(in_funct7), longint'($signed(in_imm))));
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn && !reset) begin
            checkVal("in_ready", 32'(in_ready), 32'(sbQ.size() < 2));
            checkVal("out_valid", 32'(out_valid), 32'(sbQ.size() > 0));
            if (sbQ.size() > 0) begin
                checkVal("out_inst", out_inst, sbQ[0].inst);
                checkVal("out_err", 32'(out_err), 32'(sbQ[0].err));
                checkVal("out_addr", 32'(out_addr), 32'(modelAddr));
            end
        end
    end

    logic [31:0] exp2048, expB3;
    logic        err2048, errB3;

    initial begin
        exp_t m;
`ifdef INST_ENCODER_RANGE_CHECK_EN
        exp2048 = 32'h0000_0013; err2048 = 1'b1;
        expB3   = 32'h0000_0013; errB3   = 1'b1;
`else
        exp2048 = 32'h8000_0093; err2048 = 1'b0;
        expB3   = 32'h0000_0163; errB3   = 1'b0;
`endif
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        setFields(0, 0, 0, 0, 0, 0, 0);

        m = modelEncode(1, 1, 0, 0, 0, 0, 5);
        checkVal("model_ialu", m.inst, 32'h0050_0093);
        m = modelEncode(3, 0, 1, 2, 2, 0, 8);
        checkVal("model_s", m.inst, 32'h0020_A423);
        m = modelEncode(4, 0, 0, 0, 0, 0, -4);
        checkVal("model_b", m.inst, 32'hFE00_0EE3);
        m = modelEncode(0, 3, 1, 2, 0, 32, 0);
        checkVal("model_r", m.inst, 32'h4020_81B3);
        m = modelEncode(2, 5, 2, 0, 2, 0, -4);
        checkVal("model_load", m.inst, 32'hFFC1_2283);

        repeat (2) @(negedge clk);
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("rst_out_inst", out_inst, 32'd0);
        checkVal("rst_out_err", 32'(out_err), 32'd0);
        checkVal("rst_out_addr", 32'(out_addr), 32'd0);
        reset   = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        checkVal("rst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        applyStimulus(1, 1, 0, 0, 0, 0, 5);
        checkOutput(32'h0050_0093, 1'b0, 0);
        applyStimulus(3, 0, 1, 2, 2, 0, 8);
        checkOutput(32'h0020_A423, 1'b0, 4);
        applyStimulus(4, 0, 0, 0, 0, 0, -4);
        checkOutput(32'hFE00_0EE3, 1'b0, 8);
        applyStimulus(6, 1, 2, 3, 0, 0, 5);
        checkOutput(32'h0000_0013, 1'b1, 12);
        applyStimulus(1, 1, 0, 0, 0, 0, 2048);
        checkOutput(exp2048, err2048, 0);
        applyStimulus(4, 0, 0, 0, 0, 0, 3);
        checkOutput(expB3, errB3, 4);
        @(negedge clk);

        out_ready = 1'b0;
        applyStimulus(0, 3, 1, 2, 0, 32, 0);
        applyStimulus(2, 5, 2, 0, 2, 0, -4);
        checkVal("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkVal("midrst_out_valid", 32'(out_valid), 32'd0);
        checkVal("midrst_out_addr", 32'(out_addr), 32'd0);
        checkVal("midrst_out_inst", out_inst, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkVal("midrst_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(0, 3, 1, 2, 0, 32, 0);
        applyStimulus(2, 5, 2, 0, 2, 0, -4);
        setFields(3, 0, 1, 2, 2, 0, 8);
        in_valid = 1'b1;
        checkVal("bp_in_ready_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkVal("bp_in_ready_held", 32'(in_ready), 32'd0);
        checkOutput(32'h4020_81B3, 1'b0, 0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput(32'hFFC1_2283, 1'b0, 4);
        checkVal("bp_in_ready_free", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput(32'h0020_A423, 1'b0, 8);
        @(negedge clk);
        checkVal("bp_drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 60; i++) begin
            setFields(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 9000)) - 4500);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("final_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
